// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant per bus cycle, held for the whole cyc.
// Optional slave-stall watchdog is built when WB_ARB_TIMEOUT_EN is defined.
module wb_bus_arbiter #(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AWIDTH-1:0] m0_adr_i,
  input  logic [DWIDTH-1:0] m0_dat_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DWIDTH-1:0] m0_dat_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AWIDTH-1:0] m1_adr_i,
  input  logic [DWIDTH-1:0] m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DWIDTH-1:0] m1_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AWIDTH-1:0] s_adr_o,
  output logic [DWIDTH-1:0] s_dat_o,
  input  logic              s_ack_i,
  input  logic [DWIDTH-1:0] s_dat_i,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   g_stb;
  logic   to_hit;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT must be in 2..255");
  end

  // Grant FSM; last = master served most recently, so the other one wins a tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) state <= last ? GNT0 : GNT1;
          else if (m0_cyc_i)        state <= GNT0;
          else if (m1_cyc_i)        state <= GNT1;
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            last  <= 1'b0;
            state <= m1_cyc_i ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            last  <= 1'b1;
            state <= m0_cyc_i ? GNT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_o = {state == GNT1, state == GNT0};

  // Slave-side mux from the granted master; everything low when idle.
  always_comb begin
    s_cyc_o = 1'b0;
    g_stb   = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        g_stb   = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        g_stb   = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
    s_stb_o = g_stb & ~to_hit;
  end

  assign m0_ack_o = (state == GNT0) & m0_stb_i & s_ack_i;
  assign m1_ack_o = (state == GNT1) & m1_stb_i & s_ack_i;
  assign m0_err_o = (state == GNT0) & to_hit;
  assign m1_err_o = (state == GNT1) & to_hit;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  assign to_hit = (to_cnt == CNT_W'(TIMEOUT));

  // Counts stalled strobe cycles; a dropped cyc (the only way the grant changes) clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        to_cnt <= '0;
    else if (!s_cyc_o || !g_stb || s_ack_i || to_hit) to_cnt <= '0;
    else                                              to_cnt <= to_cnt + CNT_W'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-master, one-slave Wishbone arbiter placed between the AHB-to-Wishbone bridge's Wishbone master port and the shared Wishbone slave, so that a second master (e.g. DMA or the test master) can share the slave. It grants the bus round-robin per bus cycle, holds the grant for the whole `cyc` period, and muxes the slave-side signals from the granted master. An optional watchdog terminates transfers that the slave never acknowledges.

## Interface
- `AWIDTH`, 32, address width (matches the global package).
- `DWIDTH`, 32, data width (matches the global package).
- `TIMEOUT`, 16, watchdog limit in cycles; legal range 2..255. Used only with `WB_ARB_TIMEOUT_EN`.

- `clk_i` input 1: single clock. All logic is rising-edge.
- `rst_i` input 1: **asynchronous, active-high** reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` input 1 each: master 0 cycle, strobe and write enable.
- `m0_adr_i` input AWIDTH: master 0 address.
- `m0_dat_i` input DWIDTH: master 0 write data.
- `m0_ack_o`, `m0_err_o` output 1 each: master 0 acknowledge and error.
- `m0_dat_o` output DWIDTH: master 0 read data.
- `m1_*`: identical set of ports for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` output 1 each: slave cycle, strobe and write enable.
- `s_adr_o` output AWIDTH: slave address.
- `s_dat_o` output DWIDTH: slave write data.
- `s_ack_i` input 1: slave acknowledge.
- `s_dat_i` input DWIDTH: slave read data.
- `gnt_o` output 2: one-hot grant; bit0 = m0, bit1 = m1; 00 when idle.

## Operation
- **FSM states:** IDLE, GNT0, GNT1. A `last` register holds the last-served master.
- **From IDLE**, at a clock edge:
  - One `cyc` high: go to that master's grant state.
  - Both high: grant the master that is not `last`.
  - Both low: stay in IDLE.
- **In GNTx:**
  - While `mx_cyc_i` is high, stay in GNTx. There is no preemption.
  - When `mx_cyc_i` is sampled low: set `last`=x. Go to GNTy if `my_cyc_i` is high, otherwise go to IDLE. There is no dead cycle between back-to-back grants.
- **Slave-side outputs** are combinational muxes of the granted master's `cyc`/`stb`/`we`/`adr`/`dat`. All are forced to 0 in IDLE.
- **Master-side returns:**
  - `s_ack_i` is routed only to the granted master's `ack_o`, gated by that master's `stb_i`.
  - The ungranted master's `ack_o` and `err_o` are 0.
  - `s_dat_i` drives both `m0_dat_o` and `m1_dat_o`; only `ack` qualifies the data.
- **Reset** (asynchronous, may occur mid-transfer):
  - State goes to IDLE, `last`=1 (so m0 wins the first contention), `gnt_o`=00.
  - All `s_*_o`, `mx_ack_o` and `mx_err_o` go to 0.
  - The watchdog count goes to 0.

## Timing
- **Grant latency:** a request `cyc` seen at edge N gives `gnt_o` and `s_cyc_o`/`s_stb_o` high after edge N. So there is 1 cycle of latency from a request in IDLE.
- **Handover:** the granted `cyc` low at edge N gives the other master's `s_cyc_o` high after edge N. So there is 0 dead cycles of handover.
- **ack/data path:** `ack` and data pass through combinationally with 0 added latency. Classic single and block cycles are supported. Burst length is unlimited while `cyc` is held.
- **Ungranted master:** its `stb` is ignored. It must wait with `cyc` high; no ack is returned.
- **Simultaneous events:**
  - If the granted master drops `cyc` in the same cycle as `s_ack_i`, the ack is still delivered.
  - If the granted master drops `cyc` and the other master asserts `cyc` in the same cycle, the handover happens at that edge.

## Configuration
- **Macro `WB_ARB_TIMEOUT_EN` defined:**
  - A counter of width `$clog2(TIMEOUT+1)` increments each cycle that the granted `stb` is high and `s_ack_i` is low.
  - It clears on `s_ack_i`, on a grant change, or when `stb` is low.
  - When the count equals `TIMEOUT`:
    - The granted master's `err_o` pulses high for one cycle.
    - `s_stb_o` is masked to 0 in that cycle.
    - The counter clears.
  - The grant is kept until the master drops `cyc`.
- **Macro not defined:** no counter is built, `m0_err_o`/`m1_err_o` are tied 0, and transfers may stall forever.

## Test plan
- **Reset:** assert `rst_i` mid-transfer while in GNT0 → all outputs 0 and `gnt_o`=00 immediately, without waiting for a clock edge. After release, m0 is granted first under contention.
- **Single write, m0:** m0 writes `adr`=0x0000_0010, `dat`=0xDEAD_BEEF; slave acks 2 cycles after `stb` → `gnt_o`=01 one cycle after `cyc`, `s_adr_o`/`s_dat_o` match, `m0_ack_o` pulses once, `m1_ack_o`=0.
- **Round-robin under contention:** both masters hold `cyc` and do 3 back-to-back single reads each, dropping `cyc` after every ack → grant order 0,1,0,1,0,1 with no IDLE cycle between grants.
- **Grant hold:** m1 does a 4-beat block read (`cyc` held) while m0 requests → m0 is not granted until m1 drops `cyc`. m1 receives 4 acks with `s_dat_i` values 1,2,3,4.
- **Timeout (macro on, `TIMEOUT`=4):** m0 strobes and the slave never acks → `m0_err_o` high for one cycle on the 5th stalled cycle and `s_stb_o` low in that cycle. m1 is granted after m0 drops `cyc`.
- **Timeout disabled (macro off):** same stimulus → no `err_o`, and `gnt_o` stays 01 for 100 cycles.
